// File: rtl/ram_loader_arbiter.sv
// Serial program loader and single-port RAM arbiter: parses UART load packets,
// holds the CPU and writes the payload into RAM. Optional macro: LOADER_ROMWP_EN.
module ram_loader_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] ROM_TOP        = 16'h2000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_we_i,
    output logic [15:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    output logic        ram_we_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        load_ok_o,
    output logic        load_err_o,
    output logic [2:0]  dbg_state_o
);

    // Byte stream handshake: rx_valid_i is a one-cycle strobe qualifying
    // rx_data_i; there is no back-pressure, so every strobe must be consumed
    // in the cycle it appears.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_H = 3'd1,
        S_ADDR_L = 3'd2,
        S_LEN_H  = 3'd3,
        S_LEN_L  = 3'd4,
        S_DATA   = 3'd5,
        S_CSUM   = 3'd6
    } state_t;

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_ROMWP_EN
    localparam bit ROMWP = 1'b1;
`else
    localparam bit ROMWP = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          load_ok_q, load_ok_d;
    logic          load_err_q, load_err_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic          wr_we_q, wr_we_d;
    logic [15:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          tmo_expired;
    logic          wr_allow;
    logic [15:0]   len_rx;

    assign tmo_expired = busy_q && !rx_valid_i && (tmo_q == TMO_LAST);
    assign wr_allow    = !(ROMWP && (addr_q < ROM_TOP));
    assign len_rx      = {len_q[15:8], rx_data_i};

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        load_ok_d  = 1'b0;
        load_err_d = load_err_q;
        addr_d     = addr_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_we_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        tmo_d      = tmo_q;

        // A byte on the expiry cycle wins: it resets the counter and is parsed.
        if (!busy_q || rx_valid_i) begin
            tmo_d = '0;
        end else if (!tmo_expired) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (rx_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d    = S_ADDR_H;
                        busy_d     = 1'b1;
                        load_err_d = 1'b0;
                        csum_d     = 8'h00;
                    end
                end
                S_ADDR_H: begin
                    addr_d[15:8] = rx_data_i;
                    state_d      = S_ADDR_L;
                end
                S_ADDR_L: begin
                    addr_d[7:0] = rx_data_i;
                    state_d     = S_LEN_H;
                end
                S_LEN_H: begin
                    len_d[15:8] = rx_data_i;
                    state_d     = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d   = len_rx;
                    state_d = (len_rx == 16'h0000) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    // Address, length and checksum advance even when the write is suppressed.
                    wr_we_d   = wr_allow;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_data_i;
                    addr_d    = addr_q + 16'h0001;
                    len_d     = len_q - 16'h0001;
                    csum_d    = csum_q + rx_data_i;
                    if (len_q == 16'h0001) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_data_i == csum_q) begin
                        load_ok_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else if (tmo_expired) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            load_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            addr_q     <= 16'h0000;
            len_q      <= 16'h0000;
            csum_q     <= 8'h00;
            wr_we_q    <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_data_q  <= 8'h00;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            load_ok_q  <= load_ok_d;
            load_err_q <= load_err_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            wr_we_q    <= wr_we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tmo_q      <= tmo_d;
        end
    end

    // The last payload write always lands while busy is still high (CSUM follows).
    assign ram_addr_o  = busy_q ? wr_addr_q : cpu_addr_i;
    assign ram_wdata_o = busy_q ? wr_data_q : cpu_wdata_i;
    assign ram_we_o    = busy_q ? wr_we_q   : cpu_we_i;

    assign cpu_hold_o  = busy_q;
    assign busy_o      = busy_q;
    assign load_ok_o   = load_ok_q;
    assign load_err_o  = load_err_q;
    assign dbg_state_o = state_q;

endmodule
